// File: rtl/countdown12_timer.sv
// Loadable, pausable 0..MAX_VAL down-counter with an IDLE/RUN/DONE sequencer and a one-cycle borrow pulse.
// Define AUTO_RELOAD_EN to restart from the last loaded value on expiry instead of stopping in DONE.
module countdown12_timer #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] MAX_VEC = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_VEC = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             borrow_reg, borrow_next;
    logic [WIDTH-1:0] load_clamped;
    logic             load_over;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_next;
`endif

    // Out-of-range presets saturate to MAX_VAL so cnt can never leave 0..MAX_VAL.
    assign load_over = (load_val > MAX_VEC);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_clamp
            assign load_clamped[gi] = load_over ? MAX_VEC[gi] : load_val[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            borrow_reg <= borrow_next;
`ifdef AUTO_RELOAD_EN
            reload_reg <= reload_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        borrow_next = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_next = reload_reg;
`endif
        if (load) begin
            cnt_next   = load_clamped;
            state_next = ST_IDLE;
`ifdef AUTO_RELOAD_EN
            reload_next = load_clamped;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && (cnt_reg != '0)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick && !pause) begin
                        if (cnt_reg > ONE_VEC) begin
                            cnt_next = cnt_reg - ONE_VEC;
                        end else if (cnt_reg == ONE_VEC) begin
                            borrow_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                            // A zero reload value would spin in RUN at 0, so expire normally instead.
                            if (reload_reg != '0) begin
                                cnt_next = reload_reg;
                            end else begin
                                cnt_next   = '0;
                                state_next = ST_DONE;
                            end
`else
                            cnt_next   = '0;
                            state_next = ST_DONE;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    cnt_next = '0;
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt    = cnt_reg;
        busy   = (state_reg == ST_RUN);
        done   = (state_reg == ST_DONE);
        borrow = borrow_reg;
    end

endmodule

// File: tb/tb_countdown12_timer.sv
// Bench for countdown12_timer: directed test-plan scenarios pinned with literal values,
// then randomized traffic checked every cycle against an arithmetic reference model.
module tb_countdown12_timer;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 12;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             tick;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             borrow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    countdown12_timer #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .cnt      (cnt),
        .busy     (busy),
        .done     (done),
        .borrow   (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = counting, 2 = expired.
    int m_cnt    = 0;
    int m_mode   = 0;
    bit m_borrow = 0;
`ifdef AUTO_RELOAD_EN
    int m_reload = 0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_cnt    <= 0;
            m_mode   <= 0;
            m_borrow <= 0;
`ifdef AUTO_RELOAD_EN
            m_reload <= 0;
`endif
        end else begin
            m_borrow <= 0;
            if (load) begin
                m_cnt  <= (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
                m_mode <= 0;
`ifdef AUTO_RELOAD_EN
                m_reload <= (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
`endif
            end else if (m_mode == 0) begin
                if (start && m_cnt != 0) m_mode <= 1;
            end else if (m_mode == 1 && tick && !pause) begin
                if (m_cnt == 1) begin
                    m_borrow <= 1;
`ifdef AUTO_RELOAD_EN
                    if (m_reload != 0) m_cnt <= m_reload;
                    else begin m_cnt <= 0; m_mode <= 2; end
`else
                    m_cnt  <= 0;
                    m_mode <= 2;
`endif
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_cnt", int'(cnt), m_cnt);
            check("model_busy", int'(busy), (m_mode == 1) ? 1 : 0);
            check("model_done", int'(done), (m_mode == 2) ? 1 : 0);
            check("model_borrow", int'(borrow), int'(m_borrow));
            check("cnt_range", (int'(cnt) <= MAX_VAL) ? 1 : 0, 1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input int v);
        logic [WIDTH-1:0] lv;
        lv       = WIDTH'(v);
        load     = 1'b1;
        load_val = lv;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        cyc(2);
        chk_en = 1;
        check("reset_cnt", int'(cnt), 0);
        check("reset_flags", int'({busy, done, borrow}), 0);
        rst = 1'b0;
        cyc(1);

`ifndef AUTO_RELOAD_EN
        // One-shot run from 5, ticks three cycles apart.
        pulse_load(5);
        check("t1_load", int'(cnt), 5);
        pulse_start();
        check("t1_busy", int'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            $display("t1 tick %0d: cnt=%0d borrow=%0d done=%0d", i, cnt, borrow, done);
            check("t1_cnt", int'(cnt), 5 - i);
            if (i == 5) begin
                check("t1_borrow", int'(borrow), 1);
                check("t1_done", int'(done), 1);
                check("t1_busy_off", int'(busy), 0);
            end
            cyc(2);
        end
        check("t1_borrow_once", int'(borrow), 0);
        pulse_tick();
        check("t1_hold0", int'(cnt), 0);
        check("t1_still_done", int'(done), 1);

        // Clamped load then a full 12-tick run.
        pulse_load(15);
        check("t2_clamp", int'(cnt), 12);
        pulse_start();
        repeat (11) pulse_tick();
        check("t2_cnt1", int'(cnt), 1);
        check("t2_not_done", int'(done), 0);
        pulse_tick();
        $display("t2 12th tick: cnt=%0d done=%0d borrow=%0d", cnt, done, borrow);
        check("t2_cnt0", int'(cnt), 0);
        check("t2_done", int'(done), 1);

        // Pause holds the count.
        pulse_load(4);
        pulse_start();
        pulse_tick();
        check("t3_cnt3", int'(cnt), 3);
        pause = 1'b1;
        repeat (4) pulse_tick();
        check("t3_paused", int'(cnt), 3);
        check("t3_busy", int'(busy), 1);
        pause = 1'b0;
        repeat (3) pulse_tick();
        $display("t3 after resume: cnt=%0d done=%0d", cnt, done);
        check("t3_cnt0", int'(cnt), 0);
        check("t3_done", int'(done), 1);
`else
        // Auto-reload from 2 cycles 2,1,2,1,...
        pulse_load(2);
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            pulse_tick();
            $display("ar tick %0d: cnt=%0d borrow=%0d busy=%0d", i, cnt, borrow, busy);
            check("ar_cnt", int'(cnt), (i % 2 == 1) ? 1 : 2);
            check("ar_borrow", int'(borrow), (i % 2 == 0) ? 1 : 0);
            check("ar_busy", int'(busy), 1);
            check("ar_done", int'(done), 0);
        end
`endif

        // Reset mid-run wins over everything.
        pulse_load(3);
        pulse_start();
        pulse_tick();
        check("t4_cnt2", int'(cnt), 2);
        rst = 1'b1;
        tick = 1'b1;
        cyc(1);
        rst = 1'b0;
        tick = 1'b0;
        check("t4_rst_cnt", int'(cnt), 0);
        check("t4_rst_flags", int'({busy, done, borrow}), 0);
        pulse_start();
        $display("t4 start after reset: busy=%0d cnt=%0d", busy, cnt);
        check("t4_start_ignored", int'(busy), 0);

        // Load beats start; load aborts a run.
        load = 1'b1; start = 1'b1; load_val = 4'd6;
        cyc(1);
        load = 1'b0; start = 1'b0;
        check("t5_cnt6", int'(cnt), 6);
        check("t5_idle", int'(busy), 0);
        pulse_start();
        repeat (4) pulse_tick();
        check("t5_cnt2", int'(cnt), 2);
        pulse_load(7);
        $display("t5 load during run: cnt=%0d busy=%0d", cnt, busy);
        check("t5_cnt7", int'(cnt), 7);
        check("t5_abort", int'(busy), 0);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = WIDTH'($urandom_range(0, 15));
            start    = ($urandom_range(0, 7) == 0);
            tick     = ($urandom_range(0, 2) == 0);
            pause    = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        rst = 1'b0; load = 1'b0; start = 1'b0; tick = 1'b0; pause = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
